nice_gemm_issuer: RTL and testbench
===================================

Name: nice_gemm_issuer

Overview:
- Initiator (CPU/sequencer) side of the GEMM accelerator's NICE instruction interface.
- Accepts one packed GEMM descriptor, then drives the NICE request channel in order:
  - six parameter-load instructions (funct7 one-hot 0000001..0100000);
  - one start instruction (funct7 1000000).
- Then waits on the multicycle response channel and reports completion plus an error code to the host sequencer.

Parameters:
- OPCODE, 7'b0101011, custom opcode placed in instr[6:0].
- TIMEOUT_CYCLES, 65536, watchdog limit in cycles for WAIT_RSP (used only with the timeout feature).
- TW, 17, watchdog counter width; must satisfy 2^TW > TIMEOUT_CYCLES.

Ports:
- nice_clk  in  1  clock.
- nice_rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  descriptor valid.
- cmd_ready  out  1  issuer idle, descriptor accepted on valid&ready.
- cmd_params  in  416  13x32 words, word k = bits[32k+31:32k], in this order: rhs_rows, lhs_rows, rhs_cols, bias_addr, lhs_addr, rhs_addr, lhs_offset, dst_offset, act_min, act_max, dst_multi_addr, dst_shifts_addr, dst_addr.
- nice_req_valid  out  1  request valid.
- nice_req_ready  in  1  accelerator ready.
- nice_req_instr  out  32  instruction word.
- nice_req_rs1  out  32  first operand.
- nice_req_rs2  out  32  second operand.
- nice_req_rs1_1  out  32  tied 0.
- nice_req_rs2_1  out  32  tied 0.
- nice_req_mmode  out  1  tied 0.
- nice_rsp_1cyc_type  in  1  single-cycle response flag.
- nice_rsp_1cyc_dat_1  in  32  parameter-accepted flag.
- nice_rsp_1cyc_err  in  1  single-cycle error.
- nice_rsp_multicyc_valid  in  1  completion valid.
- nice_rsp_multicyc_ready  out  1  completion ready.
- nice_rsp_multicyc_err  in  1  completion error.
- done  out  1  one-cycle pulse at end of every command.
- err_code  out  2  0=OK, 1=PARAM_REJECT, 2=INCOMPLETE, 3=TIMEOUT; held until next command accepted.

Behaviour:
- **Reset** (synchronous, active-high): state IDLE, idx=0, all registered outputs 0. cmd_ready=1 after reset. A reset mid-operation abandons the sequence; nice_req_valid is low on the cycle after the reset edge.
- **Descriptor capture:** on cmd_valid&cmd_ready the 416-bit descriptor is registered, err_code cleared to 0, and the FSM moves to ISSUE with idx=0.
- **Instruction format:** instr = {funct7, 18'b0, OPCODE}, funct7 = 7'b1 << idx. Operand pairs by idx:
  - idx 0: rs1=rhs_rows, rs2=lhs_rows.
  - idx 1: rs1=rhs_cols, rs2=bias_addr.
  - idx 2: rs1=lhs_addr, rs2=rhs_addr.
  - idx 3: rs1=lhs_offset, rs2=dst_offset.
  - idx 4: rs1=act_min, rs2=act_max.
  - idx 5: rs1=dst_multi_addr, rs2=dst_shifts_addr.
  - idx 6: rs1=dst_addr, rs2=0.
- **Request handshake:**
  - nice_req_valid is registered.
  - instr/rs1/rs2 stay stable while valid is high and ready is low; valid never drops before the handshake.
  - One instruction is transferred per valid&ready cycle. Back-to-back issue is allowed, so best case is 7 consecutive cycles.
- **Parameter instructions (idx 0..5):**
  - The 1cyc response is sampled in the handshake cycle.
  - If nice_rsp_1cyc_err=1, or nice_rsp_1cyc_dat_1[0]=0, then err_code=1, the start instruction is not issued, and the FSM goes to DONE.
  - Otherwise idx increments.
- **Start instruction (idx 6):** on handshake the FSM goes to WAIT_RSP; 1cyc inputs are ignored.
- **WAIT_RSP:**
  - nice_rsp_multicyc_ready=1 only in this state; it is 0 in every other state.
  - On multicyc valid&ready: err_code = nice_rsp_multicyc_err ? 2 : 0, then go to DONE.
- **DONE:** done=1 for exactly one cycle, then IDLE. cmd_ready=1 only in IDLE.
- **Simultaneous events:** cmd_valid arriving in DONE is not accepted until IDLE. A multicyc_valid seen outside WAIT_RSP is left pending and is not consumed.

Optional Feature:
- Macro: NICE_ISSUER_TIMEOUT_EN.
- **Defined:** a TW-bit counter clears on entry to WAIT_RSP and increments each cycle in that state. On reaching TIMEOUT_CYCLES-1 without a completion: err_code=3, go to DONE, multicyc_ready drops. A response arriving in the same cycle as expiry wins (err_code from the response).
- **Undefined:** no counter exists; WAIT_RSP is left only by a completion response.

Decomposition:
- Package nice_gemm_pkg holds:
  - OPCODE constant;
  - FUNCT7_* one-hot constants;
  - state enum {IDLE, ISSUE, WAIT_RSP, DONE};
  - err_code enum.
- Sub-module nice_param_mux (combinational): maps idx and the descriptor to {funct7, rs1, rs2}.

Test Plan:
- **Nominal command:** descriptor words k = 32'h100+k, nice_req_ready always 1, 1cyc_dat_1=1, multicyc response 20 cycles after start. Expect 7 consecutive requests with funct7 01,02,04,08,10,20,40, correct rs1/rs2 (e.g. idx2 rs1=0x104, rs2=0x105), then done pulse with err_code=0.
- **Backpressure:** nice_req_ready toggles 0/1 every cycle. instr/rs1/rs2 must stay stable while stalled; still exactly 7 handshakes.
- **Parameter rejection:** nice_rsp_1cyc_err=1 on the third parameter handshake (funct7 0000100). Expect no further requests, done, err_code=1.
- **Incomplete completion:** multicyc_err=1 with the response. Expect err_code=2, and multicyc_ready high for exactly the response-acceptance period.
- **Reset mid-operation:** nice_rst=1 while idx=3 with ready=0. Next cycle nice_req_valid=0 and cmd_ready=1; a new command restarts at funct7 0000001.
- **Timeout (NICE_ISSUER_TIMEOUT_EN, TIMEOUT_CYCLES=16):** no multicyc response. Expect done exactly 16 cycles after WAIT_RSP entry with err_code=3.

Source files
------------

// File: rtl/nice_gemm_issuer_pkg.sv
// nice_gemm_pkg: shared constants, FSM states and error codes for the NICE GEMM issuer.
package nice_gemm_pkg;
  localparam logic [6:0] NICE_OPCODE = 7'b0101011;
  localparam logic [6:0] FUNCT7_P0 = 7'b0000001;
  localparam logic [6:0] FUNCT7_P1 = 7'b0000010;
  localparam logic [6:0] FUNCT7_P2 = 7'b0000100;
  localparam logic [6:0] FUNCT7_P3 = 7'b0001000;
  localparam logic [6:0] FUNCT7_P4 = 7'b0010000;
  localparam logic [6:0] FUNCT7_P5 = 7'b0100000;
  localparam logic [6:0] FUNCT7_START = 7'b1000000;
  localparam logic [2:0] START_IDX = 3'd6;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_e;
  typedef enum logic [1:0] {ERR_OK, ERR_PARAM_REJECT, ERR_INCOMPLETE, ERR_TIMEOUT} err_code_e;
endpackage

// File: rtl/nice_gemm_issuer_if.sv
// nice_gemm_issuer_if: NICE request / response channel between issuer (master) and accelerator (slave).
interface nice_gemm_issuer_if;
  logic nice_req_valid;
  logic nice_req_ready;
  logic [31:0] nice_req_instr;
  logic [31:0] nice_req_rs1;
  logic [31:0] nice_req_rs2;
  logic [31:0] nice_req_rs1_1;
  logic [31:0] nice_req_rs2_1;
  logic nice_req_mmode;
  logic nice_rsp_1cyc_type;
  logic [31:0] nice_rsp_1cyc_dat_1;
  logic nice_rsp_1cyc_err;
  logic nice_rsp_multicyc_valid;
  logic nice_rsp_multicyc_ready;
  logic nice_rsp_multicyc_err;
  modport master(
    output nice_req_valid, nice_req_instr, nice_req_rs1, nice_req_rs2, nice_req_rs1_1, nice_req_rs2_1,
           nice_req_mmode, nice_rsp_multicyc_ready,
    input nice_req_ready, nice_rsp_1cyc_type, nice_rsp_1cyc_dat_1, nice_rsp_1cyc_err,
          nice_rsp_multicyc_valid, nice_rsp_multicyc_err
  );
  modport slave(
    input nice_req_valid, nice_req_instr, nice_req_rs1, nice_req_rs2, nice_req_rs1_1, nice_req_rs2_1,
          nice_req_mmode, nice_rsp_multicyc_ready,
    output nice_req_ready, nice_rsp_1cyc_type, nice_rsp_1cyc_dat_1, nice_rsp_1cyc_err,
           nice_rsp_multicyc_valid, nice_rsp_multicyc_err
  );
endinterface

// File: rtl/nice_gemm_issuer_param_mux.sv
// nice_param_mux: maps instruction index and packed descriptor to {funct7, rs1, rs2}.
module nice_param_mux
  import nice_gemm_pkg::*;
(
  input  logic [2:0]   i_idx,
  input  logic [415:0] i_desc,
  output logic [6:0]   o_funct7,
  output logic [31:0]  o_rs1,
  output logic [31:0]  o_rs2
);
  logic [8:0] w_base;
  // operand pair k uses descriptor words 2k and 2k+1; the start instruction has no rs2
  assign w_base = {i_idx, 6'd0};
  assign o_funct7 = FUNCT7_P0 << i_idx;
  assign o_rs1 = i_desc[w_base +: 32];
  assign o_rs2 = (i_idx == START_IDX) ? 32'h0 : i_desc[w_base + 9'd32 +: 32];
endmodule

// File: rtl/nice_gemm_issuer.sv
// nice_gemm_issuer: issues six GEMM parameter loads plus a start over NICE, then awaits completion.
// Optional watchdog on the completion wait enabled by NICE_ISSUER_TIMEOUT_EN.
module nice_gemm_issuer
  import nice_gemm_pkg::*;
#(
  parameter logic [6:0] OPCODE = NICE_OPCODE
`ifdef NICE_ISSUER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65536,
  parameter int TW = 17
`endif
) (
  input  logic                      nice_clk,
  input  logic                      nice_rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [415:0]              cmd_params,
  nice_gemm_issuer_if.master        nice,
  output logic                      done,
  output logic [1:0]                err_code
);
  state_e r_state, w_state_nxt;
  logic [2:0] r_idx, w_idx_nxt;
  logic [1:0] r_err, w_err_nxt;
  logic [415:0] r_desc;
  logic r_req_valid;
  logic w_req_hs, w_rsp_hs, w_param_nok, w_expire, w_unused;
  logic [6:0] w_funct7;
  logic [31:0] w_rs1, w_rs2;
  nice_param_mux u_mux (
    .i_idx(r_idx),
    .i_desc(r_desc),
    .o_funct7(w_funct7),
    .o_rs1(w_rs1),
    .o_rs2(w_rs2)
  );
  assign nice.nice_req_valid = r_req_valid;
  assign nice.nice_req_instr = {w_funct7, 18'b0, OPCODE};
  assign nice.nice_req_rs1 = w_rs1;
  assign nice.nice_req_rs2 = w_rs2;
  assign nice.nice_req_rs1_1 = 32'h0;
  assign nice.nice_req_rs2_1 = 32'h0;
  assign nice.nice_req_mmode = 1'b0;
  assign nice.nice_rsp_multicyc_ready = r_state == WAIT_RSP;
  assign cmd_ready = r_state == IDLE;
  assign done = r_state == DONE;
  assign err_code = r_err;
  assign w_req_hs = r_req_valid & nice.nice_req_ready;
  assign w_rsp_hs = nice.nice_rsp_multicyc_valid & (r_state == WAIT_RSP);
  assign w_param_nok = nice.nice_rsp_1cyc_err | ~nice.nice_rsp_1cyc_dat_1[0];
  assign w_unused = ^{nice.nice_rsp_1cyc_type, nice.nice_rsp_1cyc_dat_1[31:1]};
`ifdef NICE_ISSUER_TIMEOUT_EN
  logic [TW-1:0] r_tmr;
  assign w_expire = r_tmr == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge nice_clk)
    r_tmr <= (nice_rst || r_state != WAIT_RSP) ? '0 : r_tmr + TW'(1);
`else
  assign w_expire = 1'b0;
`endif
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt = r_idx;
    w_err_nxt = r_err;
    unique case (r_state)
      IDLE: if (cmd_valid) begin
        w_state_nxt = ISSUE;
        w_idx_nxt = '0;
        w_err_nxt = ERR_OK;
      end
      ISSUE: if (w_req_hs) begin
        if (r_idx == START_IDX) w_state_nxt = WAIT_RSP;
        else if (w_param_nok) begin
          w_state_nxt = DONE;
          w_err_nxt = ERR_PARAM_REJECT;
        end else w_idx_nxt = r_idx + 3'd1;
      end
      // a completion in the expiry cycle takes priority over the timeout
      WAIT_RSP: if (w_rsp_hs | w_expire) begin
        w_state_nxt = DONE;
        w_err_nxt = w_rsp_hs ? (nice.nice_rsp_multicyc_err ? ERR_INCOMPLETE : ERR_OK) : ERR_TIMEOUT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge nice_clk) begin
    if (nice_rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_err <= '0;
      r_req_valid <= 1'b0;
      r_desc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx <= w_idx_nxt;
      r_err <= w_err_nxt;
      r_req_valid <= w_state_nxt == ISSUE;
      if (cmd_valid & cmd_ready) r_desc <= cmd_params;
    end
  end
endmodule

// File: tb/tb_nice_gemm_issuer.sv
// tb_nice_gemm_issuer: scoreboard bench for nice_gemm_issuer; build with NICE_ISSUER_TIMEOUT_EN to add the watchdog test.
module tb_nice_gemm_issuer;
  logic nice_clk = 0;
  logic nice_rst = 1;
  logic cmd_valid = 0;
  logic cmd_ready;
  logic [415:0] cmd_params = '0;
  logic done;
  logic [1:0] err_code;
  nice_gemm_issuer_if ifc();
  always #5 nice_clk = ~nice_clk;
`ifdef NICE_ISSUER_TIMEOUT_EN
  nice_gemm_issuer #(.TIMEOUT_CYCLES(16), .TW(5)) dut (
`else
  nice_gemm_issuer dut (
`endif
    .nice_clk(nice_clk), .nice_rst(nice_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_params(cmd_params), .nice(ifc), .done(done), .err_code(err_code)
  );
`ifdef NICE_ISSUER_TIMEOUT_EN
  localparam int RSP_DLY = 12;
`else
  localparam int RSP_DLY = 20;
`endif
  int n_chk = 0, n_fail = 0, cyc = 0, n_hs = 0, n_done = 0, n_mrdy = 0;
  int t_entry = 0, t_done = 0, rdy_mode = 0, hs_limit = 0, rsp_delay = 0, rsp_cnt = 0;
  int hs_t[$];
  logic rsp_err = 0, rej = 0, mc_pending = 0, prev_stall = 0, prev_done = 0, prev_mrdy = 0;
  logic [95:0] prev_req;
  logic [95:0] exp_req[$];
  logic [1:0] exp_err[$];
  // accelerator model: rejects the third parameter load when rej is set
  assign ifc.nice_rsp_1cyc_type = 1'b1;
  assign ifc.nice_rsp_1cyc_dat_1 = 32'h1;
  assign ifc.nice_rsp_1cyc_err = rej && ifc.nice_req_valid && ifc.nice_req_instr[31:25] == 7'h04;
  always @(posedge nice_clk) begin
    #1;
    ifc.nice_req_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~ifc.nice_req_ready : (n_hs < hs_limit);
  end
  always @(negedge nice_clk) begin
    logic [95:0] cur, e;
    logic [1:0] ee;
    cyc++;
    cur = {ifc.nice_req_instr, ifc.nice_req_rs1, ifc.nice_req_rs2};
    if (nice_rst) begin
      prev_stall = 0; prev_done = 0; prev_mrdy = 0; mc_pending = 0; rsp_cnt = 0;
      ifc.nice_rsp_multicyc_valid = 0;
    end else begin
      if (prev_stall) begin
        n_chk++;
        if (!ifc.nice_req_valid || cur !== prev_req) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%b req=%h, required valid=1 req=%h", ifc.nice_req_valid, cur, prev_req);
        end
      end
      prev_stall = ifc.nice_req_valid && !ifc.nice_req_ready;
      prev_req = cur;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          ifc.nice_rsp_multicyc_valid = 1;
          ifc.nice_rsp_multicyc_err = rsp_err;
        end
      end
      if (ifc.nice_req_valid && ifc.nice_req_ready) begin
        n_hs++;
        hs_t.push_back(cyc);
        n_chk++;
        if (exp_req.size() == 0) begin
          n_fail++;
          $display("FAIL req_unexpected: got %h, required no request", cur);
        end else begin
          e = exp_req.pop_front();
          if (cur !== e) begin
            n_fail++;
            $display("FAIL req_data: got %h, required %h", cur, e);
          end
        end
        if (cur[95:89] == 7'h40) rsp_cnt = rsp_delay;
      end
      if (ifc.nice_rsp_multicyc_valid && ifc.nice_rsp_multicyc_ready) mc_pending = 1;
      else if (mc_pending) begin
        ifc.nice_rsp_multicyc_valid = 0;
        mc_pending = 0;
      end
      if (ifc.nice_rsp_multicyc_ready) begin
        n_mrdy++;
        if (!prev_mrdy) t_entry = cyc;
      end
      prev_mrdy = ifc.nice_rsp_multicyc_ready;
      if (prev_done) begin
        n_chk++;
        if (done !== 1'b0) begin
          n_fail++;
          $display("FAIL done_pulse: done=%b, required 0", done);
        end
      end
      if (done) begin
        n_done++;
        t_done = cyc;
        n_chk++;
        if (exp_err.size() == 0) begin
          n_fail++;
          $display("FAIL done_unexpected: err_code=%0d, required no done", err_code);
        end else begin
          ee = exp_err.pop_front();
          if (err_code !== ee) begin
            n_fail++;
            $display("FAIL err_code: got %0d, required %0d", err_code, ee);
          end
        end
      end
      prev_done = done;
    end
  end
  task automatic send_cmd(input logic [31:0] base, input int n_exp);
    int w = 0;
    logic [6:0] f;
    @(negedge nice_clk); #1;
    while (!cmd_ready && w < 200) begin
      @(negedge nice_clk); #1;
      w++;
    end
    n_chk++;
    if (!cmd_ready) begin
      n_fail++;
      $display("FAIL cmd_ready_wait: cmd_ready=%b, required 1", cmd_ready);
    end
    for (int k = 0; k < 13; k++) cmd_params[32*k +: 32] = base + 32'(k);
    for (int i = 0; i < n_exp; i++) begin
      f = 7'(1 << i);
      exp_req.push_back({f, 18'b0, 7'b0101011, base + 32'(2*i), (i == 6) ? 32'h0 : base + 32'(2*i+1)});
    end
    hs_t.delete();
    n_mrdy = 0;
    cmd_valid = 1;
    @(posedge nice_clk); #1;
    cmd_valid = 0;
  endtask
  task automatic wait_done(input int budget);
    int w = 0;
    int nd = n_done;
    while (n_done == nd && w < budget) begin
      @(negedge nice_clk); #1;
      w++;
    end
    n_chk++;
    if (n_done == nd) begin
      n_fail++;
      $display("FAIL done_wait: no done within %0d cycles, required done", budget);
    end
  endtask
  task automatic test_reset;
    ifc.nice_req_ready = 1;
    ifc.nice_rsp_multicyc_valid = 0;
    ifc.nice_rsp_multicyc_err = 0;
    nice_rst = 1;
    repeat (3) @(posedge nice_clk);
    @(negedge nice_clk); #1;
    n_chk++;
    if ({cmd_ready, ifc.nice_req_valid, ifc.nice_rsp_multicyc_ready, done, err_code} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_state: rdy/val/mrdy/done/err=%b, required 100000",
               {cmd_ready, ifc.nice_req_valid, ifc.nice_rsp_multicyc_ready, done, err_code});
    end
    nice_rst = 0;
  endtask
  task automatic test_nominal;
    rdy_mode = 0; rsp_delay = RSP_DLY; rsp_err = 0;
    exp_err.push_back(2'd0);
    send_cmd(32'h100, 7);
    wait_done(300);
    n_chk++;
    if (hs_t.size() != 7 || hs_t[6] - hs_t[0] != 6) begin
      n_fail++;
      $display("FAIL nominal_burst: %0d handshakes, required 7 consecutive", hs_t.size());
    end
    n_chk++;
    if (n_mrdy != RSP_DLY) begin
      n_fail++;
      $display("FAIL nominal_mrdy: %0d cycles, required %0d", n_mrdy, RSP_DLY);
    end
  endtask
  task automatic test_backpressure;
    rdy_mode = 1; rsp_delay = RSP_DLY; rsp_err = 0;
    exp_err.push_back(2'd0);
    send_cmd(32'h200, 7);
    wait_done(400);
    n_chk++;
    if (hs_t.size() != 7 || exp_req.size() != 0) begin
      n_fail++;
      $display("FAIL bp_count: %0d handshakes, %0d left, required 7 and 0", hs_t.size(), exp_req.size());
    end
    rdy_mode = 0;
  endtask
  task automatic test_param_reject;
    rdy_mode = 0; rej = 1;
    exp_err.push_back(2'd1);
    send_cmd(32'h300, 3);
    wait_done(100);
    repeat (10) @(negedge nice_clk);
    #1;
    n_chk++;
    if (hs_t.size() != 3 || err_code !== 2'd1 || !cmd_ready) begin
      n_fail++;
      $display("FAIL reject_stop: hs=%0d err=%0d rdy=%b, required hs=3 err=1 rdy=1", hs_t.size(), err_code, cmd_ready);
    end
    rej = 0;
  endtask
  task automatic test_incomplete;
    rdy_mode = 0; rsp_delay = 5; rsp_err = 1;
    exp_err.push_back(2'd2);
    send_cmd(32'h400, 7);
    wait_done(100);
    n_chk++;
    if (n_mrdy != 5 || ifc.nice_rsp_multicyc_ready !== 1'b0 || err_code !== 2'd2) begin
      n_fail++;
      $display("FAIL incomplete: mrdy_cycles=%0d mrdy=%b err=%0d, required 5 0 2", n_mrdy, ifc.nice_rsp_multicyc_ready, err_code);
    end
    rsp_err = 0;
  endtask
  task automatic test_reset_mid;
    int w = 0;
    rdy_mode = 2; hs_limit = n_hs + 3;
    send_cmd(32'h500, 7);
    while (!(ifc.nice_req_valid && !ifc.nice_req_ready && ifc.nice_req_instr[31:25] == 7'h08) && w < 50) begin
      @(negedge nice_clk); #1;
      w++;
    end
    n_chk++;
    if (ifc.nice_req_instr[31:25] !== 7'h08 || exp_req.size() != 4) begin
      n_fail++;
      $display("FAIL mid_stall: funct7=%h left=%0d, required 08 and 4", ifc.nice_req_instr[31:25], exp_req.size());
    end
    nice_rst = 1;
    @(negedge nice_clk); #1;
    n_chk++;
    if (ifc.nice_req_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b cmd_ready=%b, required 0 1", ifc.nice_req_valid, cmd_ready);
    end
    nice_rst = 0;
    exp_req.delete();
    rdy_mode = 0; rsp_delay = RSP_DLY;
    exp_err.push_back(2'd0);
    send_cmd(32'h600, 7);
    wait_done(300);
    n_chk++;
    if (hs_t.size() != 7) begin
      n_fail++;
      $display("FAIL mid_restart: %0d handshakes, required 7", hs_t.size());
    end
  endtask
  task automatic test_timeout;
    rdy_mode = 0; rsp_delay = 16; rsp_err = 1;
    exp_err.push_back(2'd2);
    send_cmd(32'h700, 7);
    wait_done(100);
    rsp_delay = 0; rsp_err = 0;
    exp_err.push_back(2'd3);
    send_cmd(32'h800, 7);
    wait_done(100);
    n_chk++;
    if (t_done - t_entry != 16 || n_mrdy != 16 || err_code !== 2'd3) begin
      n_fail++;
      $display("FAIL timeout: delay=%0d mrdy=%0d err=%0d, required 16 16 3", t_done - t_entry, n_mrdy, err_code);
    end
  endtask
  initial begin
    test_reset;
    test_nominal;
    test_backpressure;
    test_param_reject;
    test_incomplete;
    test_reset_mid;
`ifdef NICE_ISSUER_TIMEOUT_EN
    test_timeout;
`endif
    repeat (3) @(negedge nice_clk);
    n_chk++;
    if (exp_req.size() != 0 || exp_err.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d requests %0d dones outstanding, required 0 0", exp_req.size(), exp_err.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
